// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl (with the shared 1-bit full adder 'adder')
// Description : Bit-serial add/subtract controller. One bit per clock, LSB
//               first, carry held in a flop between bits. start/busy/done
//               handshake, registered result, carry-out and signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================

// Single-bit full adder, time-shared by the controller below.
module adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_s_sh;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_sum;
  logic               w_carry;
  logic               w_last;
  logic [WIDTH-1:0]   w_s_next;

  // The adder always sees the current LSBs and the carry of the previous bit.
  adder u_adder (
    .a     (r_a_sh[0]),
    .b     (r_b_sh[0]),
    .c     (r_carry),
    .sum   (w_sum),
    .carry (w_carry)
  );

  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_s_next = {w_sum, r_s_sh[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs; start is only honoured in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: operand capture, bit-serial shifting, and result/flag update
  // on the final bit. Subtraction is A + ~B with carry-in 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_s_sh   <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sh  <= op_a;
            r_b_sh  <= sub ? ~op_b : op_b;
            r_carry <= sub;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_s_sh  <= w_s_next;
          r_carry <= w_carry;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            result   <= w_s_next;
            cout     <= w_carry;
            // carry into MSB xor carry out of MSB
            overflow <= r_carry ^ w_carry;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder_ctrl
// Description : Scoreboard bench for serial_adder_ctrl (WIDTH=8 and WIDTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;

  typedef struct {
    logic [7:0] r;
    logic       c;
    logic       v;
  } exp_t;

  logic       clk = 1'b0;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;

  // WIDTH = 8 instance
  logic       rst8 = 1'b1, start8 = 1'b0, sub8 = 1'b0;
  logic [7:0] op_a8 = '0, op_b8 = '0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] result8;

  // WIDTH = 4 instance
  logic       rst4 = 1'b1, start4 = 1'b0, sub4 = 1'b0;
  logic [3:0] op_a4 = '0, op_b4 = '0;
  logic       busy4, done4, cout4, ovf4;
  logic [3:0] result4;

  exp_t q8[$];
  exp_t q4[$];
  exp_t held8;
  int   done_times[$];
  int   done4_cnt = 0;
  bit   mon_en = 1'b0;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .sub(sub8), .op_a(op_a8), .op_b(op_b8),
    .busy(busy8), .done(done8), .result(result8), .cout(cout8), .overflow(ovf8)
  );

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .sub(sub4), .op_a(op_a4), .op_b(op_b4),
    .busy(busy4), .done(done4), .result(result4), .cout(cout4), .overflow(ovf4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(input int w, input int a, input int b, input bit s);
    exp_t e;
    int m, sa, sb, sres, raw;
    m    = 1 << w;
    raw  = s ? (a - b) : (a + b);
    e.r  = 8'(((raw % m) + m) % m);
    e.c  = s ? (a >= b) : (a + b >= m);
    sa   = (a >= m / 2) ? a - m : a;
    sb   = (b >= m / 2) ? b - m : b;
    sres = s ? (sa - sb) : (sa + sb);
    e.v  = (sres < -(m / 2)) || (sres >= m / 2);
    return e;
  endfunction

  // Monitor for the 8-bit instance: compares on done, checks output stability otherwise.
  always @(negedge clk) begin
    if (mon_en) begin
      if (done8) begin
        done_times.push_back(cyc);
        chk("busy_low_in_done8", {31'd0, busy8}, 32'd0);
        if (q8.size() == 0) begin
          chk("unexpected_done8", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q8.pop_front();
          chk("result8", {24'd0, result8}, {24'd0, e.r});
          chk("cout8", {31'd0, cout8}, {31'd0, e.c});
          chk("overflow8", {31'd0, ovf8}, {31'd0, e.v});
          held8 = e;
        end
      end else if ({result8, cout8, ovf8} !== {held8.r, held8.c, held8.v}) begin
        chk("stable8", {22'd0, result8, cout8, ovf8}, {22'd0, held8.r, held8.c, held8.v});
      end
    end
  end

  // Monitor for the 4-bit instance.
  always @(negedge clk) begin
    if (mon_en && done4) begin
      done4_cnt++;
      if (q4.size() == 0) begin
        chk("unexpected_done4", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        chk("result4", {28'd0, result4}, {28'd0, e.r[3:0]});
        chk("cout4", {31'd0, cout4}, {31'd0, e.c});
        chk("overflow4", {31'd0, ovf4}, {31'd0, e.v});
      end
    end
  end

  // Issue one 8-bit operation and check busy span and done latency.
  task automatic op8(input int a, input int b, input bit s);
    int lat;
    bit seen;
    @(negedge clk);
    op_a8 = 8'(a); op_b8 = 8'(b); sub8 = s; start8 = 1'b1;
    q8.push_back(model(8, a, b, s));
    @(posedge clk);
    #1;
    start8 = 1'b0;
    op_a8 = 8'($urandom); op_b8 = 8'($urandom); sub8 = 1'($urandom);
    lat = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      if (done8) seen = 1'b1;
      else begin
        if (busy8 !== 1'b1) chk("busy8_during_run", {31'd0, busy8}, 32'd1);
        lat++;
      end
    end
    chk("latency8", lat, 8);
  endtask

  task automatic op4(input int a, input int b, input bit s);
    int n;
    bit seen;
    @(negedge clk);
    op_a4 = 4'(a); op_b4 = 4'(b); sub4 = s; start4 = 1'b1;
    q4.push_back(model(4, a, b, s));
    @(posedge clk);
    #1;
    start4 = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 12) begin
      @(negedge clk);
      if (done4) seen = 1'b1;
      n++;
    end
    if (!seen) chk("timeout4", 32'd1, 32'd0);
  endtask

  initial begin
    held8 = '{r: 8'd0, c: 1'b0, v: 1'b0};
    repeat (3) @(posedge clk);
    #1;
    rst8 = 1'b0; rst4 = 1'b0;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy8}, 32'd0);
    chk("reset_done", {31'd0, done8}, 32'd0);
    chk("reset_result", {24'd0, result8}, 32'd0);
    chk("reset_cout", {31'd0, cout8}, 32'd0);
    chk("reset_overflow", {31'd0, ovf8}, 32'd0);
    mon_en = 1'b1;

    // Directed add/sub cases including carry and overflow boundaries.
    op8(23, 42, 0);
    op8(8'hFF, 8'h01, 0);
    op8(8'h7F, 8'h01, 0);
    op8(8'h05, 8'h07, 1);
    op8(8'h80, 8'h01, 1);
    op8(8'h10, 8'h10, 1);

    // start pulse during RUN must be ignored.
    @(negedge clk);
    op_a8 = 8'd10; op_b8 = 8'd20; sub8 = 1'b0; start8 = 1'b1;
    q8.push_back(model(8, 10, 20, 0));
    @(posedge clk); #1 start8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    op_a8 = 8'hAA; op_b8 = 8'h55; start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    repeat (12) @(negedge clk);
    chk("ignored_start_queue", q8.size(), 0);

    // start held high: three back-to-back operations, 10 cycles apart.
    done_times.delete();
    @(negedge clk);
    op_a8 = 8'h33; op_b8 = 8'h44; sub8 = 1'b0; start8 = 1'b1;
    repeat (3) q8.push_back(model(8, 8'h33, 8'h44, 0));
    repeat (21) @(posedge clk);
    #1 start8 = 1'b0;
    repeat (15) @(negedge clk);
    chk("held_start_pulses", done_times.size(), 3);
    if (done_times.size() == 3) begin
      chk("period_1", done_times[1] - done_times[0], 10);
      chk("period_2", done_times[2] - done_times[1], 10);
    end

    // Reset in the middle of RUN aborts the operation.
    @(negedge clk);
    op_a8 = 8'd100; op_b8 = 8'd100; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst8 = 1'b1;
    @(posedge clk);
    #1;
    rst8 = 1'b0;
    held8 = '{r: 8'd0, c: 1'b0, v: 1'b0};
    @(negedge clk);
    chk("abort_busy", {31'd0, busy8}, 32'd0);
    chk("abort_result", {24'd0, result8}, 32'd0);
    chk("abort_cout", {31'd0, cout8}, 32'd0);
    chk("abort_overflow", {31'd0, ovf8}, 32'd0);
    repeat (12) @(negedge clk);
    op8(3, 4, 0);

    // Randomized operations.
    repeat (40) op8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'($urandom));

    // Exhaustive 4-bit sweep.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int s = 0; s < 2; s++)
          op4(a, b, 1'(s));
    repeat (4) @(negedge clk);
    chk("done_count4", done4_cnt, 512);
    chk("q8_drained", q8.size(), 0);
    chk("q4_drained", q4.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
